// File: rtl/riscv_encoder_if.sv
// Request/response bundle for riscv_encoder: instruction fields in, encoded words out.
// The requester holds the master modport; the encoder holds the slave modport.
interface riscv_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_illegal;

  modport master (
    output in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
    output in_rd, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_illegal
  );

  modport slave (
    input  in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
    input  in_rd, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_illegal
  );
endinterface

// File: rtl/riscv_encoder.sv
// RV32 instruction encoder feeding a DEPTH-entry output FIFO; illegal requests enqueue 0 + flag.
// Optional macro RVENC_M_EXT_EN: when defined, M-extension R-type requests encode normally.
module riscv_encoder #(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  riscv_encoder_if.slave   bus,
  output logic [31:0]      enc_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  logic [31:0] imm;
  logic        fits12;
  logic        fits13;
  logic        fits21;
  logic [31:0] enc_word;
  logic        enc_bad;
  logic [31:0] enc_instr;

  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW:0]   count_reg, count_next;
  logic [31:0]   enc_count_reg, enc_count_next;
  logic          full;
  logic          push;
  logic          pop;

  logic [31:0] mem_instr [DEPTH];
  logic        mem_ill   [DEPTH];

  assign imm = bus.in_imm;

  // A value fits N signed bits when every bit above N-1 matches the sign bit.
  assign fits12 = (&imm[31:11]) | ~(|imm[31:11]);
  assign fits13 = (&imm[31:12]) | ~(|imm[31:12]);
  assign fits21 = (&imm[31:20]) | ~(|imm[31:20]);

`ifndef RVENC_M_EXT_EN
  logic is_mext;
  assign is_mext = (bus.in_funct7 == 7'b0000001) &&
                   ((bus.in_opcode == 7'b0110011) || (bus.in_opcode == 7'b0111011));
`endif

  always_comb begin
    enc_word = 32'h0;
    enc_bad  = 1'b0;
    case (bus.in_fmt)
      FMT_R: begin
        enc_word = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                    bus.in_rd, bus.in_opcode};
`ifdef RVENC_M_EXT_EN
        enc_bad  = 1'b0;
`else
        enc_bad  = is_mext;
`endif
      end
      FMT_I: begin
        enc_word = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
        enc_bad  = !fits12;
      end
      FMT_S: begin
        enc_word = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                    imm[4:0], bus.in_opcode};
        enc_bad  = !fits12;
      end
      FMT_B: begin
        enc_word = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                    imm[4:1], imm[11], bus.in_opcode};
        enc_bad  = !fits13 || imm[0];
      end
      FMT_U: begin
        enc_word = {imm[31:12], bus.in_rd, bus.in_opcode};
        enc_bad  = |imm[11:0];
      end
      FMT_J: begin
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, bus.in_opcode};
        enc_bad  = !fits21 || imm[0];
      end
      default: begin
        enc_word = 32'h0;
        enc_bad  = 1'b1;
      end
    endcase
  end

  assign enc_instr = enc_bad ? 32'h0 : enc_word;

  // Full blocks acceptance outright; a same-cycle pop does not open a slot early.
  assign full          = (count_reg == (AW+1)'(DEPTH));
  assign bus.in_ready  = !full;
  assign bus.out_valid = (count_reg != '0);
  assign push          = bus.in_valid && !full;
  assign pop           = bus.out_valid && bus.out_ready;

  always_comb begin
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    count_next     = count_reg;
    enc_count_next = enc_count_reg;
    if (push) begin
      wr_ptr_next = wr_ptr_reg + 1'b1;
    end
    if (pop) begin
      rd_ptr_next    = rd_ptr_reg + 1'b1;
      enc_count_next = enc_count_reg + 32'd1;
    end
    if (push && !pop) begin
      count_next = count_reg + 1'b1;
    end else if (pop && !push) begin
      count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      enc_count_reg <= 32'h0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      enc_count_reg <= enc_count_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (reset) begin
          mem_instr[gi] <= 32'h0;
          mem_ill[gi]   <= 1'b0;
        end else if (push && (wr_ptr_reg == AW'(gi))) begin
          mem_instr[gi] <= enc_instr;
          mem_ill[gi]   <= enc_bad;
        end
      end
    end
  endgenerate

  // Head entry is forced to zero when empty so stale slots never leak out.
  assign bus.out_instr   = bus.out_valid ? mem_instr[rd_ptr_reg] : 32'h0;
  assign bus.out_illegal = bus.out_valid ? mem_ill[rd_ptr_reg] : 1'b0;
  assign enc_count       = enc_count_reg;

endmodule

// File: doc/riscv_encoder.md
RISCV_ENCODER -- requirements
Module: riscv_encoder

Interface
REQ-001 SHALL have parameter: DEPTH, 2, output FIFO entries (power of two, >=2).
REQ-002 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: in_valid  input  1  request present.
REQ-005 SHALL have port: in_ready  output  1  request accepted when in_valid&in_ready.
REQ-006 SHALL have ports: in_fmt input 3 (0=R,1=I,2=S,3=B,4=U,5=J,6-7 reserved); in_opcode input 7; in_funct3 input 3; in_funct7 input 7.
REQ-007 SHALL have ports: in_rd, in_rs1, in_rs2  input  5 each  register indices.
REQ-008 SHALL have port: in_imm  input  32  signed immediate/offset in bytes.
REQ-009 SHALL have ports: out_valid output 1; out_ready input 1; out_instr output 32 encoded word; out_illegal output 1 encode-failure flag.
REQ-010 SHALL have port: enc_count  output  32  count of words delivered.

Function
REQ-011 SHALL encode R as {funct7,rs2,rs1,funct3,rd,opcode}.
REQ-012 SHALL encode I as {imm[11:0],rs1,funct3,rd,opcode}; legal imm range -2048..2047 (shift funct bits supplied in imm[11:5] by caller).
REQ-013 SHALL encode S as {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}; range -2048..2047.
REQ-014 SHALL encode B as {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}; range -4096..4094, imm[0] must be 0.
REQ-015 SHALL encode U as {imm[31:12],rd,opcode}; imm[11:0] must be 0.
REQ-016 SHALL encode J as {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}; range -1048576..1048574, imm[0] must be 0.
REQ-017 SHALL, on reserved fmt or any range/alignment violation, enqueue out_instr=32'h0 with out_illegal=1 (entry still delivered, never dropped).
REQ-018 SHALL encode and write the result into the FIFO in the acceptance cycle; out_valid rises the following cycle when FIFO was empty (latency 1).
REQ-019 SHALL drive in_ready = !full; no bypass when full, even if out_ready=1 that cycle.
REQ-020 SHALL pop on out_valid&out_ready; out_instr/out_illegal hold stable while out_valid&!out_ready.
REQ-021 SHALL keep occupancy unchanged on simultaneous push and pop; pointers wrap modulo DEPTH.
REQ-022 SHALL deliver words in acceptance order.
REQ-023 SHALL increment enc_count by 1 per pop (legal or illegal), wrapping 32'hFFFFFFFF->0.

Reset
REQ-024 SHALL, on reset, empty FIFO, clear pointers, drive out_valid=0, out_instr=0, out_illegal=0, enc_count=0, in_ready=1 the cycle after.
REQ-025 SHALL discard all queued entries and any same-cycle request when reset asserts mid-operation.

Configuration
REQ-026 SHALL, with RVENC_M_EXT_EN defined, encode R with funct7=7'b0000001 and opcode 0110011/0111011 normally.
REQ-027 SHALL, without RVENC_M_EXT_EN, treat those M-extension requests as illegal per REQ-017.

Verification
REQ-028 SHALL cover: ADDI fmt=1,opc=0010011,f3=0,rd=1,rs1=2,imm=5 -> out_instr=0x00510093, illegal=0, one cycle after accept.
REQ-029 SHALL cover: BEQ fmt=3,opc=1100011,f3=0,rs1=1,rs2=2,imm=8 -> 0x00208463; imm=7 -> 0x0, illegal=1.
REQ-030 SHALL cover: JAL fmt=5,opc=1101111,rd=1,imm=2048 -> 0x001000EF; I-type imm=2048 -> 0x0, illegal=1.
REQ-031 SHALL cover: MUL fmt=0,opc=0110011,f7=1,rd=3,rs1=1,rs2=2 -> 0x022081B3 with RVENC_M_EXT_EN, else 0x0 illegal=1.
REQ-032 SHALL cover: DEPTH=2, out_ready=0, three back-to-back requests -> in_ready=0 after second accept; releasing out_ready drains in order, enc_count=2.
REQ-033 SHALL cover: reset asserted with FIFO full -> next cycle out_valid=0, enc_count=0, in_ready=1.
